shift_unit: RTL and testbench
=============================

SHIFT_UNIT -- requirements
Module: shift_unit

Interface
REQ-001 Parameters: none; the data width is fixed at 32 bits and the amount width at 8 bits.
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  Rising-edge clock for all state.
REQ-004 rst_n  in  1  Asynchronous active-low reset.
REQ-005 start  in  1  Request a shift; sampled on a rising clk edge in IDLE only.
REQ-006 abort  in  1  Synchronous cancel of the operation in progress.
REQ-007 sh_type  in  2  Shift type: LSL=0, LSR=1, ASR=2, ROR=3.
REQ-008 sh_amt  in  8  Shift amount, 0-255 (register-specified range).
REQ-009 op_in  in  32  Operand to shift (Rm value).
REQ-010 carry_in  in  1  Current C flag.
REQ-011 busy  out  1  High in every state except IDLE.
REQ-012 done  out  1  Single-cycle pulse; result and carry_out are valid while it is high.
REQ-013 result  out  32  Shifted operand; feeds the ALU src2 input.
REQ-014 carry_out  out  1  Shifter carry; feeds the ALU shifter-carry input.

Function
REQ-015 FSM states: IDLE, SHIFT, DONE.
REQ-016 IDLE with start=1 at a clock edge: latch op_in into result, carry_in into carry_out, sh_type, and the step count N, then go to SHIFT if N>0, else go to DONE.
REQ-017 Step count N:
- sh_amt=0: N=0 for every type.
- LSL/LSR: N=min(sh_amt,33).
- ASR: N=min(sh_amt,32).
- ROR, sh_amt nonzero: N=sh_amt[4:0], or 32 when sh_amt[4:0]=0.
REQ-018 Each SHIFT cycle performs exactly one 1-bit step and decrements the count. The step per type:
- LSL: carry_out<=result[31], zero fill.
- LSR: carry_out<=result[0], zero fill.
- ASR: carry_out<=result[0], result[31] fill.
- ROR: carry_out<=result[0], result[0] moves into bit 31.
REQ-019 SHIFT goes to DONE on the edge that performs the final step (count 1 to 0).
REQ-020 DONE: done=1 for exactly one cycle, then IDLE on the next edge.
REQ-021 Latency: done is high in the cycle after edge E0+N, where E0 is the accepting edge.
REQ-022 result and carry_out hold their values after DONE until the next accepted start.
REQ-023 start is ignored while busy=1; no queuing.
REQ-024 abort=1 in SHIFT or DONE: go to IDLE on the next edge; no done pulse in SHIFT, and the remainder of the DONE pulse is suppressed.
REQ-025 abort has priority over start; result and carry_out are left as they were.
REQ-026 The resulting boundary behaviour (ARM-compatible):
- LSL/LSR by 32: result 0, carry = the last bit shifted out.
- LSL/LSR by more than 32: result 0, carry 0.
- ASR by 32 or more: result all sign bits, carry = sign.
- ROR by a multiple of 32: result unchanged, carry = op_in[31].
REQ-027 sh_amt=0: result=op_in, carry_out=carry_in, and done appears one cycle after acceptance.
REQ-028 sh_type, sh_amt, op_in and carry_in are don't-care outside the accepting edge.

Reset
REQ-029 rst_n low asynchronously forces: state IDLE, count 0, result 32'h0, carry_out 0, busy 0, done 0.
REQ-030 Reset during SHIFT or DONE discards the operation; no done pulse follows the deassertion of reset.
REQ-031 The first start is accepted on the first rising edge at which rst_n is high.

Structure
REQ-032 A shared package shift_pkg holds:
- the sh_type enum (LSL, LSR, ASR, ROR);
- the FSM state enum (IDLE, SHIFT, DONE);
- constants MAX_LSL_STEPS=33 and MAX_ASR_STEPS=32.
REQ-033 One combinational sub-module, shift_step, computes the 1-bit step: inputs type, value, carry; outputs the next value and next carry. shift_unit instantiates it once.

Verification
REQ-034 LSL, op_in=32'h8000_0001, sh_amt=1, carry_in=0 -> result=32'h0000_0002, carry_out=1, done in the 2nd cycle after acceptance.
REQ-035 LSR, op_in=32'h8000_0000, sh_amt=32 -> result=0, carry_out=1 after 32 steps; repeat with sh_amt=33 -> result=0, carry_out=0 after 33 steps.
REQ-036 ASR, op_in=32'h8000_0000, sh_amt=40 -> result=32'hFFFF_FFFF, carry_out=1, done after exactly 32 steps.
REQ-037 ROR, op_in=32'h0000_0001, sh_amt=1 -> 32'h8000_0000, carry 1; ROR, op_in=32'h8000_0000, sh_amt=64 -> 32'h8000_0000, carry 1, 32 steps.
REQ-038 sh_amt=0, op_in=32'h1234_5678, carry_in=1, any sh_type -> result unchanged, carry_out=1, done one cycle after acceptance.
REQ-039 Robustness:
- start pulsed mid-SHIFT: ignored, busy stays 1.
- abort at step 3 of 10: IDLE next edge, no done pulse.
- rst_n low at step 5: all outputs 0 immediately.

Source files
------------

// File: rtl/shift_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// shift_pkg : shared types, limits and step-count helper for shift_unit
// Rev 1.0
// ------------------------------------------------------------------
package shift_pkg;

  typedef enum logic [1:0] {
    LSL = 2'd0,
    LSR = 2'd1,
    ASR = 2'd2,
    ROR = 2'd3
  } sh_type_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [5:0] MAX_LSL_STEPS = 6'd33;
  localparam logic [5:0] MAX_ASR_STEPS = 6'd32;

  // Beyond these limits, further 1-bit steps would not change result or carry.
  function automatic logic [5:0] calc_steps(input sh_type_e t, input logic [7:0] amt);
    logic [5:0] n;
    n = 6'd0;
    if (amt != 8'd0) begin
      case (t)
        LSL, LSR: n = (amt > {2'b00, MAX_LSL_STEPS}) ? MAX_LSL_STEPS : amt[5:0];
        ASR:      n = (amt > {2'b00, MAX_ASR_STEPS}) ? MAX_ASR_STEPS : amt[5:0];
        default:  n = (amt[4:0] == 5'd0) ? 6'd32 : {1'b0, amt[4:0]};
      endcase
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/shift_unit_if.sv
`default_nettype none
// ------------------------------------------------------------------
// shift_unit_if : request/result bundle between a requester and shift_unit
// Rev 1.0
// ------------------------------------------------------------------
interface shift_unit_if;
  import shift_pkg::*;

  logic        start;
  logic        abort;
  sh_type_e    sh_type;
  logic [7:0]  sh_amt;
  logic [31:0] op_in;
  logic        carry_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        carry_out;

  modport master (
    output start, abort, sh_type, sh_amt, op_in, carry_in,
    input  busy, done, result, carry_out
  );

  modport slave (
    input  start, abort, sh_type, sh_amt, op_in, carry_in,
    output busy, done, result, carry_out
  );

endinterface
`default_nettype wire

// File: rtl/shift_step.sv
`default_nettype none
// ------------------------------------------------------------------
// shift_step : combinational single-bit LSL/LSR/ASR/ROR step with carry
// Rev 1.0
// ------------------------------------------------------------------
module shift_step
  import shift_pkg::*;
(
  input  sh_type_e    i_type,
  input  logic [31:0] i_value,
  input  logic        i_carry,
  output logic [31:0] o_value,
  output logic        o_carry
);

  always_comb begin
    o_value = i_value;
    o_carry = i_carry;
    case (i_type)
      LSL: begin
        o_value = {i_value[30:0], 1'b0};
        o_carry = i_value[31];
      end
      LSR: begin
        o_value = {1'b0, i_value[31:1]};
        o_carry = i_value[0];
      end
      ASR: begin
        o_value = {i_value[31], i_value[31:1]};
        o_carry = i_value[0];
      end
      ROR: begin
        o_value = {i_value[0], i_value[31:1]};
        o_carry = i_value[0];
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/shift_unit.sv
`default_nettype none
// ------------------------------------------------------------------
// shift_unit : iterative ARM-style barrel-shifter replacement, one bit per cycle
// Rev 1.0
// ------------------------------------------------------------------
module shift_unit
  import shift_pkg::*;
(
  input  wire          clk,
  input  wire          rst_n,
  shift_unit_if.slave  sif
);

  state_e      r_state;
  sh_type_e    r_type;
  logic [5:0]  r_cnt;
  logic [31:0] r_result;
  logic        r_carry;
  logic        r_busy;
  logic        r_done;

  logic [5:0]  w_steps;
  logic [31:0] w_next_value;
  logic        w_next_carry;

  assign w_steps = calc_steps(sif.sh_type, sif.sh_amt);

  shift_step u_step (
    .i_type  (r_type),
    .i_value (r_result),
    .i_carry (r_carry),
    .o_value (w_next_value),
    .o_carry (w_next_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_type   <= LSL;
      r_cnt    <= 6'd0;
      r_result <= 32'h0;
      r_carry  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          // abort outranks start even when nothing is in flight
          if (sif.start && !sif.abort) begin
            r_result <= sif.op_in;
            r_carry  <= sif.carry_in;
            r_type   <= sif.sh_type;
            r_cnt    <= w_steps;
            r_busy   <= 1'b1;
            if (w_steps != 6'd0) begin
              r_state <= SHIFT;
            end else begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (sif.abort) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= 6'd0;
          end else begin
            r_result <= w_next_value;
            r_carry  <= w_next_carry;
            r_cnt    <= r_cnt - 6'd1;
            if (r_cnt == 6'd1) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_cnt   <= 6'd0;
        end
      endcase
    end
  end

  assign sif.busy      = r_busy;
  assign sif.done      = r_done;
  assign sif.result    = r_result;
  assign sif.carry_out = r_carry;

endmodule
`default_nettype wire

// File: tb/tb_shift_unit.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_shift_unit : randomized and directed self-checking bench for shift_unit
// Rev 1.0
// ------------------------------------------------------------------
module tb_shift_unit;
  import shift_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  shift_unit_if sif ();

  shift_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sif   (sif.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: whole-operation ARM shifter semantics via wide arithmetic.
  task automatic model(input int t, input int amt, input logic [31:0] op, input logic cin,
                       output logic [31:0] res, output logic cout, output int lat);
    logic [63:0]        tmp;
    logic signed [63:0] stmp;
    int                 r;
    res = op;
    cout = cin;
    lat = 0;
    if (amt != 0) begin
      case (t)
        0: begin
          tmp  = {32'h0, op} << amt;
          res  = tmp[31:0];
          cout = tmp[32];
          lat  = (amt > 33) ? 33 : amt;
        end
        1: begin
          tmp  = {op, 32'h0} >> amt;
          res  = tmp[63:32];
          cout = tmp[31];
          lat  = (amt > 33) ? 33 : amt;
        end
        2: begin
          r    = (amt > 32) ? 32 : amt;
          stmp = $signed({op, 32'h0}) >>> r;
          res  = stmp[63:32];
          cout = stmp[31];
          lat  = r;
        end
        default: begin
          r    = amt % 32;
          res  = (op >> r) | (op << (32 - r));
          cout = res[31];
          lat  = (r == 0) ? 32 : r;
        end
      endcase
    end
  endtask

  task automatic drive_req(input int t, input int amt, input logic [31:0] op, input logic cin);
    sif.start    = 1'b1;
    sif.sh_type  = sh_type_e'(t[1:0]);
    sif.sh_amt   = amt[7:0];
    sif.op_in    = op;
    sif.carry_in = cin;
  endtask

  task automatic scramble_inputs();
    sif.sh_type  = sh_type_e'($urandom_range(0, 3));
    sif.sh_amt   = 8'($urandom_range(0, 255));
    sif.op_in    = $urandom;
    sif.carry_in = 1'($urandom_range(0, 1));
  endtask

  // poke_at >= 0 pulses a competing start after that many cycles.
  task automatic run_op(input int t, input int amt, input logic [31:0] op, input logic cin,
                        input int poke_at);
    logic [31:0] er;
    logic        ec;
    int          el;
    int          k;
    model(t, amt, op, cin, er, ec, el);
    @(negedge clk);
    drive_req(t, amt, op, cin);
    @(posedge clk);
    #1;
    sif.start = 1'b0;
    scramble_inputs();
    k = 0;
    while (sif.done !== 1'b1 && k < 400) begin
      if (k == poke_at) begin
        @(negedge clk);
        drive_req($urandom_range(0, 3), $urandom_range(1, 255), $urandom, 1'b1);
        @(posedge clk);
        #1;
        sif.start = 1'b0;
        check("busy_after_poke", {31'h0, sif.busy}, 32'h1);
      end else begin
        @(posedge clk);
        #1;
      end
      k++;
    end
    check("latency", 32'(k), 32'(el));
    check("result", sif.result, er);
    check("carry", {31'h0, sif.carry_out}, {31'h0, ec});
    check("busy_at_done", {31'h0, sif.busy}, 32'h1);
    @(posedge clk);
    #1;
    check("done_single", {31'h0, sif.done}, 32'h0);
    check("idle_after", {31'h0, sif.busy}, 32'h0);
    check("result_hold", sif.result, er);
    check("carry_hold", {31'h0, sif.carry_out}, {31'h0, ec});
  endtask

  initial begin
    logic [31:0] er;
    logic        ec;
    int          el;
    int          amt;
    int          sel;
    int          seen;
    logic [31:0] op;
    int          picks[6];
    picks = '{0, 1, 31, 32, 33, 64};

    sif.start = 1'b0;
    sif.abort = 1'b0;
    scramble_inputs();
    #12;
    check("rst_result", sif.result, 32'h0);
    check("rst_carry", {31'h0, sif.carry_out}, 32'h0);
    check("rst_busy", {31'h0, sif.busy}, 32'h0);
    check("rst_done", {31'h0, sif.done}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(0, 1, 32'h8000_0001, 1'b0, -1);
    run_op(1, 32, 32'h8000_0000, 1'b0, -1);
    run_op(1, 33, 32'h8000_0000, 1'b0, -1);
    run_op(2, 40, 32'h8000_0000, 1'b0, -1);
    run_op(3, 1, 32'h0000_0001, 1'b0, -1);
    run_op(3, 64, 32'h8000_0000, 1'b0, -1);
    for (int t = 0; t < 4; t++) run_op(t, 0, 32'h1234_5678, 1'b1, -1);
    run_op(0, 32, 32'h0000_0001, 1'b0, -1);
    run_op(0, 200, 32'hFFFF_FFFF, 1'b1, -1);

    // competing start mid-operation must be dropped
    run_op(0, 10, 32'hA5A5_0F0F, 1'b0, 3);

    // abort after three of ten steps
    op = $urandom;
    model(1, 3, op, 1'b0, er, ec, el);
    @(negedge clk);
    drive_req(1, 10, op, 1'b0);
    @(posedge clk);
    #1;
    sif.start = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    sif.abort = 1'b1;
    @(posedge clk);
    #1;
    sif.abort = 1'b0;
    check("abort_busy", {31'h0, sif.busy}, 32'h0);
    check("abort_result", sif.result, er);
    check("abort_carry", {31'h0, sif.carry_out}, {31'h0, ec});
    seen = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (sif.done === 1'b1) seen++;
    end
    check("abort_no_done", 32'(seen), 32'h0);

    // reset in the middle of a shift
    @(negedge clk);
    drive_req(2, 20, 32'h8765_4321, 1'b1);
    @(posedge clk);
    #1;
    sif.start = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_result", sif.result, 32'h0);
    check("mid_rst_carry", {31'h0, sif.carry_out}, 32'h0);
    check("mid_rst_busy", {31'h0, sif.busy}, 32'h0);
    check("mid_rst_done", {31'h0, sif.done}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (sif.done === 1'b1 || sif.busy === 1'b1) seen++;
    end
    check("post_rst_quiet", 32'(seen), 32'h0);

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 2);
      if (sel == 0)      amt = $urandom_range(0, 40);
      else if (sel == 1) amt = picks[$urandom_range(0, 5)];
      else               amt = $urandom_range(0, 255);
      run_op($urandom_range(0, 3), amt, $urandom, 1'($urandom_range(0, 1)), -1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
